// File: rtl/fifo_2port.sv
// Single-clock FIFO built on a two-port RAM (one write port, one registered read port).
// Pointers carry an extra wrap bit so full and empty can be told apart with equal low bits.
module fifo_2port #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WREN,
    input  logic                  RDEN,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] PtrInc = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                wr_ok;
    logic                rd_ok;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    end

    // A read on a full FIFO frees the slot being written, so the write is still taken.
    always_comb begin
        wr_ok = WREN && (!full || RDEN) && !reset;
        rd_ok = RDEN && !empty && !reset;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PtrInc;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PtrInc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_2port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (data_out)
    );

endmodule

// Two-port RAM: storage is never reset; only the read data register is cleared.
module fifo_2port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read-before-write when a full FIFO reads and writes the same slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: tb/tb_fifo_2port.sv
// Directed bench for fifo_2port: reset, basic order, full/empty boundaries, wrap and mid-stream reset.
module tb_fifo_2port;

    logic       clk;
    logic       reset;
    logic       WREN;
    logic       RDEN;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0] model_q [$];
    logic [7:0] exp_out;

    fifo_2port #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .WREN     (WREN),
        .RDEN     (RDEN),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        WREN    = w;
        RDEN    = r;
        data_in = d;
    endtask

    initial begin
        // 1: reset with requests asserted
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h55);
        tick();
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_dout", {24'd0, data_out}, 32'h00);
        reset = 1'b0;

        // 2: three writes then one read
        drive(1'b1, 1'b0, 8'h1B);
        tick();
        check("w1_empty", {31'd0, empty}, 32'd0);
        drive(1'b1, 1'b0, 8'h3B);
        tick();
        drive(1'b1, 1'b0, 8'h5B);
        tick();
        check("w3_full", {31'd0, full}, 32'd0);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        check("r1_dout", {24'd0, data_out}, 32'h1B);

        // 3: simultaneous read/write keeps occupancy at 2
        drive(1'b1, 1'b1, 8'h7B);
        tick();
        check("rw1_dout", {24'd0, data_out}, 32'h3B);
        tick();
        check("rw2_dout", {24'd0, data_out}, 32'h5B);
        tick();
        check("rw3_dout", {24'd0, data_out}, 32'h7B);
        check("rw_empty", {31'd0, empty}, 32'd0);
        check("rw_full", {31'd0, full}, 32'd0);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        check("rw_tail1", {24'd0, data_out}, 32'h7B);
        tick();
        check("rw_tail2", {24'd0, data_out}, 32'h7B);
        check("rw_drained", {31'd0, empty}, 32'd1);

        // 4: fill, overflow, drain
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            tick();
            check("fill_full", {31'd0, full}, (i == 7) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 1'b0, 8'hFF);
        tick();
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_dout", {24'd0, data_out}, 32'h00);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
            check("drain_dout", {24'd0, data_out}, 32'(i));
            check("drain_empty", {31'd0, empty}, (i == 7) ? 32'd1 : 32'd0);
        end

        // 5: read+write while full, then underflow
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i));
            tick();
        end
        check("refill_full", {31'd0, full}, 32'd1);
        drive(1'b1, 1'b1, 8'hAA);
        tick();
        check("frw_dout", {24'd0, data_out}, 32'h10);
        check("frw_full", {31'd0, full}, 32'd1);
        for (int i = 1; i < 9; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
            check("frw_drain", {24'd0, data_out}, (i == 8) ? 32'hAA : 32'(8'h10 + i));
        end
        check("frw_empty", {31'd0, empty}, 32'd1);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        check("udf_dout", {24'd0, data_out}, 32'hAA);
        check("udf_empty", {31'd0, empty}, 32'd1);
        // Read on empty with a write: write lands, read is ignored (no bypass)
        drive(1'b1, 1'b1, 8'hC3);
        tick();
        check("nobyp_dout", {24'd0, data_out}, 32'hAA);
        check("nobyp_empty", {31'd0, empty}, 32'd0);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        check("nobyp_read", {24'd0, data_out}, 32'hC3);

        // 6: long mixed traffic across pointer wrap against a queue model
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        reset = 1'b0;
        model_q.delete();
        exp_out = 8'h00;
        for (int i = 0; i < 48; i++) begin
            logic w, r, w_ok, r_ok;
            w = (i < 24) ? 1'b1 : (i % 3 == 0);
            r = (i < 24) ? (i % 3 == 0) : 1'b1;
            w_ok = w && ((model_q.size() < 8) || r);
            r_ok = r && (model_q.size() > 0);
            drive(w, r, 8'(i * 7 + 3));
            if (r_ok) exp_out = model_q.pop_front();
            if (w_ok) model_q.push_back(8'(i * 7 + 3));
            tick();
            check("wrap_dout", {24'd0, data_out}, {24'd0, exp_out});
            check("wrap_empty", {31'd0, empty}, (model_q.size() == 0) ? 32'd1 : 32'd0);
            check("wrap_full", {31'd0, full}, (model_q.size() == 8) ? 32'd1 : 32'd0);
        end

        // Mid-stream reset with content present
        drive(1'b1, 1'b0, 8'h99);
        tick();
        drive(1'b1, 1'b0, 8'h9A);
        tick();
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h9B);
        tick();
        reset = 1'b0;
        check("mrst_empty", {31'd0, empty}, 32'd1);
        check("mrst_full", {31'd0, full}, 32'd0);
        check("mrst_dout", {24'd0, data_out}, 32'h00);
        drive(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
